// File: rtl/pc_seq_ctrl_pkg.sv
// Shared constants for the next-PC sequencer: address width, vectors, FSM and select encodings.
// Optional build macro: PC_ALIGN_CHK_EN (enables the target alignment check in pc_seq_ctrl).
package pc_seq_ctrl_pkg;

    localparam int ADDRWIDTH = 32;

    localparam logic [ADDRWIDTH-1:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [ADDRWIDTH-1:0] EXC_VEC_DEF   = 32'h0000_0180;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    // Encoded in priority order, highest first.
    typedef enum logic [2:0] {
        SEL_EXC  = 3'd0,
        SEL_ERET = 3'd1,
        SEL_BR   = 3'd2,
        SEL_JMP  = 3'd3,
        SEL_PEND = 3'd4,
        SEL_SEQ  = 3'd5
    } sel_e;

    function automatic logic misaligned(input logic [ADDRWIDTH-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_if.sv
// Core-side signal bundle of the next-PC sequencer; slave is the sequencer, master is the core.
// Optional build macro: PC_ALIGN_CHK_EN (adds adel_o).
interface pc_seq_ctrl_if
    import pc_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDRWIDTH
) ();
    // Level-qualified requests, sampled every cycle; no valid/ready handshake on this bundle.
    logic [ADDR_W-1:0] pc_cur_i;
    logic              stall_i;
    logic              br_taken_i;
    logic [ADDR_W-1:0] br_target_i;
    logic              jmp_i;
    logic [ADDR_W-1:0] jmp_target_i;
    logic              exc_i;
    logic [ADDR_W-1:0] exc_pc_i;
    logic              eret_i;
    logic [ADDR_W-1:0] pc_next_o;
    logic              keep_o;
    logic              flush_o;
    logic [ADDR_W-1:0] epc_o;
    logic [1:0]        state_o;
`ifdef PC_ALIGN_CHK_EN
    logic              adel_o;
`endif

    modport slave (
        input  pc_cur_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
        input  exc_i, exc_pc_i, eret_i,
        output pc_next_o, keep_o, flush_o, epc_o, state_o
`ifdef PC_ALIGN_CHK_EN
        , output adel_o
`endif
    );

    modport master (
        output pc_cur_i, stall_i, br_taken_i, br_target_i, jmp_i, jmp_target_i,
        output exc_i, exc_pc_i, eret_i,
        input  pc_next_o, keep_o, flush_o, epc_o, state_o
`ifdef PC_ALIGN_CHK_EN
        , input adel_o
`endif
    );

endinterface

// File: rtl/pc_pend_buf.sv
// Pending-redirect register: holds a branch/jump target that arrived while the PC was stalled.
// Clear wins over capture; a capture while already valid overwrites (latest redirect wins).
module pc_pend_buf
    import pc_seq_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDRWIDTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cap_i,
    input  logic [ADDR_W-1:0] cap_addr_i,
    input  logic              clr_i,
    output logic              vld_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (clr_i) begin
            vld_d = 1'b0;
        end else if (cap_i) begin
            vld_d  = 1'b1;
            addr_d = cap_addr_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            addr_q <= '0;
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign vld_o  = vld_q;
    assign addr_o = addr_q;

endmodule

// File: rtl/pc_seq_ctrl.sv
// Next-PC sequencer and hold controller: priority next-PC mux, stall-safe redirect buffering,
// IF/ID flush generation and EPC. Optional build macro: PC_ALIGN_CHK_EN (target alignment check, adel_o).
module pc_seq_ctrl
    import pc_seq_ctrl_pkg::*;
#(
    parameter int                ADDR_W    = ADDRWIDTH,
    parameter logic [ADDR_W-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [ADDR_W-1:0] EXC_VEC   = EXC_VEC_DEF,
    parameter int                FLUSH_CYC = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pc_seq_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] epc_q, epc_d;

    sel_e              sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] pc_next_raw;
    logic              keep;
    logic              applied;
    logic              capture;
    logic              adel_hit;

    logic              pend_vld;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_clr;

    assign keep = bus.stall_i & ~bus.exc_i & ~bus.eret_i;

    always_comb begin
        sel      = SEL_SEQ;
        sel_addr = bus.pc_cur_i + ADDR_W'(4);
        if (bus.exc_i) begin
            sel      = SEL_EXC;
            sel_addr = EXC_VEC;
        end else if (bus.eret_i) begin
            sel      = SEL_ERET;
            sel_addr = epc_q;
        end else if (bus.br_taken_i) begin
            sel      = SEL_BR;
            sel_addr = bus.br_target_i;
        end else if (bus.jmp_i) begin
            sel      = SEL_JMP;
            sel_addr = bus.jmp_target_i;
        end else if (pend_vld && !bus.stall_i) begin
            sel      = SEL_PEND;
            sel_addr = pend_addr;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic adel_q;

    // Only a target actually being applied can fault; a stalled branch is checked when it drains.
    assign adel_hit = ~keep && (sel == SEL_ERET || sel == SEL_BR || sel == SEL_JMP || sel == SEL_PEND)
                      && misaligned(sel_addr);

    always_ff @(posedge clk_i) begin
        if (rst_i) adel_q <= 1'b0;
        else       adel_q <= adel_hit;
    end

    assign bus.adel_o = adel_q;
`else
    assign adel_hit = 1'b0;
`endif

    assign pc_next_raw = adel_hit ? EXC_VEC : sel_addr;
    assign applied     = ~keep && (sel != SEL_SEQ);
    assign capture     = bus.stall_i & (bus.br_taken_i | bus.jmp_i) & ~bus.exc_i & ~bus.eret_i;
    // Pending target is consumed (or superseded) as soon as the stall drops.
    assign pend_clr    = bus.exc_i | bus.eret_i | (pend_vld & ~bus.stall_i);

    pc_pend_buf #(
        .ADDR_W (ADDR_W)
    ) u_pend_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .cap_i      (capture),
        .cap_addr_i (bus.br_taken_i ? bus.br_target_i : bus.jmp_target_i),
        .clr_i      (pend_clr),
        .vld_o      (pend_vld),
        .addr_o     (pend_addr)
    );

    always_comb begin
        epc_d = epc_q;
        if (bus.exc_i)   epc_d = bus.exc_pc_i;
        else if (adel_hit) epc_d = sel_addr;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (capture) begin
            state_d = ST_HOLD;
        end else if (applied) begin
            state_d = ST_FLUSH;
            cnt_d   = 2'(FLUSH_CYC);
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (!bus.stall_i) state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if (cnt_q <= 2'd1) begin
                        state_d = ST_RUN;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= 2'd0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
        end
    end

    assign bus.pc_next_o = rst_i ? RESET_VEC : pc_next_raw;
    assign bus.keep_o    = ~rst_i & keep;
    assign bus.flush_o   = ~rst_i & (state_q == ST_FLUSH);
    assign bus.epc_o     = epc_q;
    assign bus.state_o   = state_q;

endmodule

// File: doc/pc_seq_ctrl.md
Name: pc_seq_ctrl

Overview:
- Next-PC sequencer and hold controller for the pipelined MIPS core's PC register. Drives that register's next-address and keep inputs.
- Arbitrates between these next-PC sources: exception vector, ERET return, branch, jump, a buffered pending redirect, and sequential PC+4.
- Buffers redirects that arrive during a stall so they are never lost.
- Generates IF/ID flush pulses and holds the EPC register.

Parameters:
ADDR_W, 32, PC width; must equal the core-wide `ADDRWIDTH.
RESET_VEC, 32'h0000_0000, pc_next_o value while rst_i is high.
EXC_VEC, 32'h0000_0180, exception entry address.
FLUSH_CYC, 1, cycles flush_o stays high after a redirect is applied (1..3).

Ports:
clk_i  in  1  single clock; all state updates on posedge.
rst_i  in  1  synchronous, active-high reset.
pc_cur_i  in  ADDR_W  current PC register output.
stall_i  in  1  load-use/structural hazard hold request.
br_taken_i  in  1  branch resolved taken (ID stage).
br_target_i  in  ADDR_W  branch target.
jmp_i  in  1  jump/jr in ID.
jmp_target_i  in  ADDR_W  jump target.
exc_i  in  1  exception request; PC of faulting instruction is exc_pc_i.
exc_pc_i  in  ADDR_W  PC to save into EPC.
eret_i  in  1  return from exception.
pc_next_o  out  ADDR_W  next PC to the PC register.
keep_o  out  1  PC register hold.
flush_o  out  1  flush IF/ID pipeline register.
epc_o  out  ADDR_W  saved exception PC.
state_o  out  2  FSM state, for debug.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset (rst_i=1 at a posedge):
  - state=RUN; pend_vld=0; epc=0; flush counter=0.
  - While rst_i is high: pc_next_o=RESET_VEC, keep_o=0, flush_o=0.
- pc_next_o is combinational. Priority order:
  1. exc_i -> EXC_VEC
  2. eret_i -> epc
  3. br_taken_i -> br_target_i
  4. jmp_i -> jmp_target_i
  5. pend_vld & ~stall_i -> pend_addr
  6. otherwise -> pc_cur_i + 4, modulo 2^ADDR_W (wraps to 0 at the top).
- keep_o = stall_i & ~exc_i & ~eret_i. Exception and ERET always override stall.
- Redirect while stalled:
  - br_taken_i or jmp_i with stall_i=1 and no exc_i/eret_i: the target is captured into pend_addr and pend_vld is set at the posedge.
  - State goes to HOLD. keep_o=1.
  - If br_taken_i and jmp_i are both high, only the branch target is captured.
- A newer redirect while in HOLD overwrites pend_addr (the last one wins).
- exc_i or eret_i in any state clears pend_vld.
- On exc_i, epc <= exc_pc_i at the posedge. epc holds otherwise.
- FSM transitions:
  - RUN -> HOLD: redirect with stall, as above.
  - RUN -> FLUSH: an applied redirect, i.e. exc/eret/branch/jump with keep_o=0. Load counter = FLUSH_CYC.
  - HOLD -> FLUSH: stall_i falls. pend_addr is driven on pc_next_o that cycle; pend_vld clears.
  - HOLD -> HOLD: stall_i stays high.
  - FLUSH -> RUN: counter reaches 0.
  - A new applied redirect while in FLUSH reloads the counter and stays in FLUSH.
- flush_o is registered: high during every cycle spent in FLUSH, so it asserts the cycle after the redirect is applied and stays high for exactly FLUSH_CYC cycles.
- Mid-operation reset: state, pend_vld and counter are cleared immediately at the posedge; any pending redirect is discarded.
- State encoding: RUN=0, HOLD=1, FLUSH=2.

Optional Feature:
PC_ALIGN_CHK_EN
- Defined:
  - A selected next-PC (branch, jump, pending or ERET target) with bits [1:0]!=0 is treated as an internal address-error exception.
  - pc_next_o=EXC_VEC and epc <= the misaligned target.
  - Adds output adel_o: a one-cycle registered pulse. Reset value 0.
- Not defined: no check is made, targets pass through unchanged, and adel_o is absent.

Decomposition:
- Shared package/defines file holds:
  - ADDRWIDTH
  - EXC_VEC and RESET_VEC defaults
  - 2-bit state encodings RUN/HOLD/FLUSH
  - priority-select encoding constants
- One natural sub-module: pc_pend_buf. It is the pending-redirect register (pend_vld/pend_addr) with capture, overwrite and clear inputs.
- The next-PC mux and FSM stay in pc_seq_ctrl.

Test Plan:
1. Reset then free run: rst_i=1 for 2 cycles, then release with pc_cur_i following pc_next_o -> pc_next_o=0, then 4, 8, 0xC; keep_o=0; flush_o=0.
2. Branch unstalled: pc_cur_i=0x40, br_taken_i=1, target 0x100 for 1 cycle -> pc_next_o=0x100 that cycle; flush_o high exactly 1 cycle (FLUSH_CYC=1) starting the next cycle.
3. Redirect during stall: stall_i=1 for 3 cycles; jmp_i with target 0x200 pulses in cycle 1 -> keep_o=1 for 3 cycles, state_o=1. Then:
   - When stall falls, pc_next_o=0x200 and flush follows.
   - A second jump to 0x300 in cycle 2 -> 0x300 is used instead.
4. Exception overrides stall: stall_i=1, exc_i=1, exc_pc_i=0x84 -> keep_o=0, pc_next_o=0x180, epc_o=0x84 next cycle, pending cleared. A later eret_i -> pc_next_o=0x84.
5. Simultaneous branch (0x100) and jump (0x200) unstalled -> pc_next_o=0x100. With exc_i also high -> 0x180.
6. With PC_ALIGN_CHK_EN defined, branch to 0x102 -> pc_next_o=0x180, adel_o pulses 1 cycle, epc_o=0x102.
